seq_detect_param: RTL

Parametrised Moore serial-pattern detector, successor to the fixed 6-bit non-overlapping detector. It samples one bit per enabled cycle and raises a one-cycle registered match pulse whenever the most recent `cfg_len` bits equal a runtime-loaded pattern. Overlapping or non-overlapping detection is selectable at runtime, and a saturating match counter is included. It sits on the serial data path feeding status/interrupt logic. Reset defaults reproduce the previous block's pattern, 110101, in non-overlapping mode.

---
 rtl/seq_detect_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Moore serial-pattern detector with a runtime-loaded pattern, a runtime
// length, and a runtime overlap mode. It samples one bit per enabled cycle,
// pulses y for one cycle when the most recent len bits equal the pattern,
// and keeps a saturating count of matches.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides all other inputs
//   en           sample x this cycle
//   x            serial data bit
//   cfg_load     strobe: capture cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  pattern; bit len-1 is received first, bit 0 last
//   cfg_len      active length (clamped to MAX_LEN; 0 disables detection)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      clear match_count (a clear coincident with a hit gives 1)
//   y            registered one-cycle match pulse
//   match_count  saturating match counter
//   count_sat    registered flag, high while match_count is all ones
//
// Detection state is the fill level of the history register:
//   state      | meaning
//   fill = 0   | no valid bits (after reset, load, or a non-overlapping hit)
//   0<fill<len | collecting bits, no match possible yet
//   fill >= len| last len bits are valid and are compared on every sample
module seq_detect_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0011_0101),
   parameter int                 RST_LEN     = 6,
   parameter logic               RST_OVERLAP = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               x,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               y,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_n;
   logic [MAX_LEN-1:0] pat;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   fill_inc;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   len_ld;
   logic               ovl;
   logic               hit;
   logic [CNT_W-1:0]   count_n;

   always_comb begin
      hist_n   = {hist[MAX_LEN-2:0], x};
      fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

      // Compare only the low len bits of history against the pattern.
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len);
      end

      hit = en && !cfg_load && (len != '0) && (fill_inc >= len) &&
            (((hist_n ^ pat) & mask) == '0);

      count_n = match_count;
      if (hit) begin
         if (cnt_clr)
            count_n = CNT_W'(1);
         else if (!(&match_count))
            count_n = match_count + 1'b1;
      end else if (cnt_clr) begin
         count_n = '0;
      end

      len_ld = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist        <= '0;
         fill        <= '0;
         y           <= 1'b0;
         match_count <= '0;
         count_sat   <= 1'b0;
         pat         <= RST_PATTERN;
         len         <= LEN_W'(RST_LEN);
         ovl         <= RST_OVERLAP;
      end else begin
         match_count <= count_n;
         count_sat   <= &count_n;
         if (cfg_load) begin
            pat  <= cfg_pattern;
            len  <= len_ld;
            ovl  <= cfg_overlap;
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
         end else if (en) begin
            hist <= hist_n;
            // Non-overlapping: a hit consumes all valid bits, but the bit
            // sampled in the following (y-high) cycle is still taken.
            fill <= (hit && !ovl) ? '0 : fill_inc;
            y    <= hit;
         end else begin
            y <= 1'b0;
         end
      end
   end

endmodule
